control_sequencer: RTL and testbench

Hardwired control unit that drives the mini-CPU datapath through the fetch/execute sequence T0–T5, one instruction at a time. It reads the instruction register contents and emits the per-cycle strobes the datapath needs: bus drivers, register enables, memory read and ALU operation. It handles memory wait states with a timeout and supports start, stop and halt. It sits beside the datapath and replaces the hand-written per-state stimulus used in early bring-up.

---
 rtl/control_sequencer.sv | 173 +++++++++++++++++
 tb/tb_control_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0-T5 fetch/execute control unit for the mini-CPU datapath
module control_sequencer #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        instr_done,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       stop_pending_q, stop_pending_d;
  logic       fault_q, fault_d;

  logic [4:0] opcode;
  logic       is_alu;
  logic       stop_now;
  logic       ir_unused;

  assign opcode   = ir[31:27];
  assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
  assign stop_now = stop_pending_q | stop;
  // Register fields are decoded by the datapath's select/encode logic.
  assign ir_unused = ^ir[26:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= 8'd0;
      stop_pending_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stop_pending_q <= stop_pending_d;
      fault_q        <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    alu_op     = 4'b0000;
    run        = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        run        = 1'b1;
        wait_cnt_d = 8'd0;
        state_d    = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        run     = 1'b1;
        // Data arriving on the last allowed wait cycle still wins over the timeout.
        if (mem_ready) begin
          state_d = S_T2;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        run     = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        Grb  = 1'b1;
        Rout = 1'b1;
        Yin  = 1'b1;
        run  = 1'b1;
        if (opcode == OP_HALT)  state_d = S_HALT;
        else if (is_alu)        state_d = S_T4;
        else if (stop_now)      state_d = S_IDLE;
        else                    state_d = S_T0;
      end
      S_T4: begin
        Grc  = 1'b1;
        Rout = 1'b1;
        Zin  = 1'b1;
        run  = 1'b1;
        case (opcode)
          OP_ADD:  alu_op = 4'b0001;
          OP_SUB:  alu_op = 4'b0010;
          OP_AND:  alu_op = 4'b0011;
          OP_OR:   alu_op = 4'b0100;
          default: alu_op = 4'b0000;
        endcase
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout    = 1'b1;
        Gra        = 1'b1;
        Rin        = 1'b1;
        run        = 1'b1;
        instr_done = 1'b1;
        state_d    = stop_now ? S_IDLE : S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    stop_pending_d = (state_d == S_IDLE) ? 1'b0 : stop_now;
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized scripted bench for control_sequencer
module tb_control_sequencer;

  localparam int MAXW = 4;

  localparam int B_PCOUT = 22, B_ZLOWOUT = 21, B_MDROUT = 20, B_MARIN = 19;
  localparam int B_ZIN = 18, B_PCIN = 17, B_MDRIN = 16, B_IRIN = 15, B_YIN = 14;
  localparam int B_INCPC = 13, B_READ = 12, B_GRA = 11, B_GRB = 10, B_GRC = 9;
  localparam int B_RIN = 8, B_ROUT = 7, B_RUN = 2, B_DONE = 1;

  logic        clock = 1'b0;
  logic        clear, start, stop, mem_ready;
  logic [31:0] ir;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic        Gra, Grb, Grc, Rin, Rout, run, instr_done, fault;
  logic [3:0]  alu_op;
  logic [22:0] dut_vec;

  control_sequencer #(.MAX_WAIT(MAXW)) dut (
    .clock(clock), .clear(clear), .start(start), .stop(stop), .ir(ir),
    .mem_ready(mem_ready), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .alu_op(alu_op), .run(run), .instr_done(instr_done), .fault(fault)
  );

  always #5 clock = ~clock;

  assign dut_vec = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
                    Read, Gra, Grb, Grc, Rin, Rout, alu_op, run, instr_done, fault};

  typedef struct {
    logic        clr, st, sp, mr;
    logic [31:0] irv;
    logic [22:0] exp;
    string       tag;
  } ent_t;

  ent_t        q[$];
  logic [22:0] exp_cur;
  string       cur_tag;
  bit          chk = 0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always @(negedge clock) begin
    if (chk) begin
      total++;
      if (dut_vec !== exp_cur) begin
        bad++;
        $display("FAIL %s cycle=%0d got=%06h expected=%06h", cur_tag, cyc, dut_vec, exp_cur);
      end
      if ((cur_tag == "reset" || cur_tag == "post_reset") && (dut_vec !== 23'h0)) begin
        bad++;
        $display("FAIL reset_state cycle=%0d got=%06h", cyc, dut_vec);
      end
      if ((cur_tag == "halt_fault") &&
          ((fault !== 1'b1) || (run !== 1'b0) || (dut_vec[22:3] !== 20'h0))) begin
        bad++;
        $display("FAIL wait_expired cycle=%0d fault=%b run=%b got=%06h", cyc, fault, run, dut_vec);
      end
    end
  end

  function automatic bit op_is_alu(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd6);
  endfunction

  // Strobe set for one step of an instruction, straight from the per-step lists.
  function automatic logic [22:0] phase_vec(input int ph, input logic [4:0] op);
    logic [22:0] v;
    v = '0;
    case (ph)
      0: begin v[B_PCOUT] = 1; v[B_MARIN] = 1; v[B_INCPC] = 1; v[B_ZIN] = 1; end
      1: begin v[B_ZLOWOUT] = 1; v[B_PCIN] = 1; v[B_READ] = 1; v[B_MDRIN] = 1; end
      2: begin v[B_MDROUT] = 1; v[B_IRIN] = 1; end
      3: begin v[B_GRB] = 1; v[B_ROUT] = 1; v[B_YIN] = 1; end
      4: begin
        v[B_GRC] = 1; v[B_ROUT] = 1; v[B_ZIN] = 1;
        if (op_is_alu(op)) v[6:3] = 4'(op - 5'd2);
      end
      5: begin v[B_ZLOWOUT] = 1; v[B_GRA] = 1; v[B_RIN] = 1; v[B_DONE] = 1; end
      default: v = '0;
    endcase
    v[B_RUN] = 1;
    return v;
  endfunction

  task automatic push(input logic clr, input logic st, input logic sp, input logic mr,
                      input logic [31:0] irv, input logic [22:0] exp, input string tag);
    ent_t e;
    e.clr = clr; e.st = st; e.sp = sp; e.mr = mr; e.irv = irv; e.exp = exp; e.tag = tag;
    q.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic from_idle(input bit sws);
    int k;
    k = $urandom_range(0, 2);
    repeat (k) push(0, 0, 0, rb(), $urandom, '0, "idle");
    push(0, 1, sws, rb(), $urandom, '0, "idle_start");
  endtask

  // One instruction starting at T0; to_idle reports whether the sequencer rests in IDLE afterwards.
  task automatic push_instr(input logic [4:0] op, input int waits, input int stop_at,
                            input int clr_at, input bit pre_stop, output bit to_idle);
    int   phs[$];
    logic mrs[$];
    bit   timeout, stopped;
    int   n;
    logic [31:0] irv;
    timeout = (waits >= MAXW);
    phs.push_back(0); mrs.push_back(rb());
    for (int i = 0; i < (timeout ? MAXW : waits); i++) begin
      phs.push_back(1); mrs.push_back(1'b0);
    end
    if (!timeout) begin
      phs.push_back(1); mrs.push_back(1'b1);
      phs.push_back(2); mrs.push_back(rb());
      phs.push_back(3); mrs.push_back(rb());
      if (op_is_alu(op)) begin
        phs.push_back(4); mrs.push_back(rb());
        phs.push_back(5); mrs.push_back(rb());
      end
    end
    stopped = pre_stop;
    for (int i = 0; i < phs.size(); i++) begin
      irv = $urandom;
      if (phs[i] >= 2) irv[31:27] = op;
      if (i == clr_at) begin
        push(1, rb(), 0, rb(), irv, '0, "clear_mid");
        to_idle = 1;
        return;
      end
      push(0, rb(), 1'(i == stop_at), mrs[i], irv, phase_vec(phs[i], op),
           $sformatf("T%0d_op%0d", phs[i], op));
      if (i == stop_at) stopped = 1;
    end
    if (timeout || op == 5'd27) begin
      n = timeout ? 20 : $urandom_range(3, 8);
      repeat (n) push(0, rb(), rb(), rb(), $urandom, timeout ? 23'h1 : 23'h0,
                      timeout ? "halt_fault" : "halt_op");
      push(1, 0, 0, rb(), $urandom, '0, "halt_clear");
      to_idle = 1;
      return;
    end
    to_idle = stopped;
  endtask

  initial begin
    ent_t        e;
    bit          ti, sws;
    logic [4:0]  op;
    int          r, waits, stop_at, clr_at;
    logic [31:0] and_ir;

    clear = 1; start = 0; stop = 0; mem_ready = 0; ir = '0;
    and_ir = 32'h2891_8000;

    push(1, 0, 0, 0, '0, '0, "reset");
    push(1, 1, 0, 0, '0, '0, "reset");
    push(0, 0, 0, 1, '0, '0, "post_reset");
    push(0, 1, 0, 1, and_ir, '0, "idle_start");
    push(0, 0, 0, 1, and_ir, 23'h4C2004, "and_T0");
    push(0, 0, 0, 1, and_ir, 23'h231004, "and_T1");
    push(0, 0, 0, 1, and_ir, 23'h108004, "and_T2");
    push(0, 0, 0, 1, and_ir, 23'h004484, "and_T3");
    push(0, 0, 0, 1, and_ir, 23'h04029C, "and_T4");
    push(0, 0, 0, 1, and_ir, 23'h200906, "and_T5");
    push_instr(5'd3, 3, 1, -1, 0, ti);
    from_idle(0);
    push_instr(5'd26, 0, -1, -1, 0, ti);
    push_instr(5'd3, 0, -1, 3, 0, ti);
    from_idle(0);
    push_instr(5'd4, MAXW, -1, -1, 0, ti);
    from_idle(0);
    push_instr(5'd27, 1, -1, -1, 0, ti);
    from_idle(1);
    push_instr(5'd5, MAXW - 1, -1, -1, 1, ti);
    push(0, 0, 0, 1, '0, '0, "idle_after_stop");

    ti = 1;
    repeat (60) begin
      sws = 0;
      if (ti) begin
        sws = ($urandom_range(0, 3) == 0);
        from_idle(sws);
      end
      r = $urandom_range(0, 9);
      if (r < 4)       op = 5'(3 + r);
      else if (r == 4) op = 5'd26;
      else if (r == 5) op = 5'd27;
      else             op = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 11);
      waits   = (r == 0) ? MAXW : (r == 1) ? MAXW - 1 : $urandom_range(0, 2);
      stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1;
      clr_at  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1;
      push_instr(op, waits, stop_at, clr_at, sws, ti);
    end

    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clock);
      #1;
      cyc++;
      clear = e.clr; start = e.st; stop = e.sp; mem_ready = e.mr; ir = e.irv;
      exp_cur = e.exp;
      cur_tag = e.tag;
      chk = 1;
    end
    @(posedge clock);
    #1;
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
